seq_radix4_divider: RTL and testbench
=====================================

# seq_radix4_divider

Sequential signed radix-4 restoring divider producing 2 quotient bits per clock. It is the inverse arithmetic companion to the sequential radix-4 Booth multiplier and sits beside it in the datapath. It accepts a WIDTH-bit dividend and divisor on a start pulse. It returns quotient, remainder and a divide-by-zero flag with a one-cycle done pulse.

## Interface
- WIDTH, 32, operand width; must be even and ≥ 4.
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset, synchronous, active-high.
- start  in  1  request; sampled only when busy=0.
- dividend  in  WIDTH  signed two's-complement numerator; sampled with start.
- divisor  in  WIDTH  signed two's-complement denominator; sampled with start.
- busy  out  1  high from the cycle after start is accepted until the cycle before done.
- done  out  1  one-cycle pulse; results valid from this cycle.
- quotient  out  WIDTH  signed quotient, truncated toward zero.
- remainder  out  WIDTH  signed remainder; takes the sign of the dividend; |remainder| < |divisor|.
- div_by_zero  out  1  set with the results when divisor==0.

## Operation
- FSM states: IDLE, PREP, ITER, FIX, DONE. Reset state is IDLE.
- IDLE or DONE with start=1:
  - capture dividend, divisor and their sign bits;
  - go to PREP.
- start while busy=1 is ignored. No queueing.
- PREP:
  - form magnitudes |N| and |D| as unsigned WIDTH bits, so -2^(WIDTH-1) is representable;
  - precompute 2D and 3D at WIDTH+2 bits.
  - If D==0: quotient=all ones, remainder=dividend (raw), div_by_zero=1, go to DONE.
  - Otherwise: clear the partial remainder R (WIDTH+2 bits), set cnt=WIDTH/2-1, go to ITER.
- ITER, one radix-4 step per cycle:
  - R' = {R, N[WIDTH-1:WIDTH-2]}; shift N left by 2.
  - Digit q = 3/2/1/0 for the largest multiple of D (3D, 2D, D, 0) that is ≤ R'.
  - R = R' - q·D; shift q into the quotient register at the LSB.
  - On cnt==0 go to FIX; otherwise decrement cnt.
- FIX:
  - negate the quotient if the operand signs differ;
  - negate the remainder if the dividend was negative;
  - load outputs, div_by_zero=0, go to DONE.
- DONE: done=1 for exactly one cycle. Next state is PREP if start=1, else IDLE.
- Overflow case -2^(WIDTH-1) / -1 gives quotient -2^(WIDTH-1) and remainder 0, with no flag. This is the natural wrap.
- quotient, remainder and div_by_zero hold their values until the next result load.
- Reset mid-operation: any state returns to IDLE. All outputs are 0; internal registers are cleared.

## Timing
- Reset values: busy=0, done=0, quotient=0, remainder=0, div_by_zero=0.
- Start sampled high at cycle 0 (the edge ending cycle 0).
- Normal path:
  - cycle 1 PREP;
  - cycles 2..WIDTH/2+1 ITER;
  - cycle WIDTH/2+2 FIX;
  - done in cycle WIDTH/2+3 (cycle 19 for WIDTH=32).
- Divide by zero: done in cycle 2.
- busy=1 in cycles 1 through the cycle before done. busy=0 in the done cycle, so back-to-back start is accepted there.
- All outputs are registered. No combinational path from inputs to outputs.

## Structure
- Package div_pkg: state enum (IDLE/PREP/ITER/FIX/DONE), default WIDTH constant, DBZ quotient constant (all ones).
- Sub-module radix4_digit_select: combinational.
  - Inputs: R', D, 2D, 3D.
  - Outputs: 2-bit digit and next R.
  - Instantiated once in ITER.
- Top level holds the FSM, counter, operand and sign registers, and the output registers.

## Test plan
- 100 / 7 -> quotient 14, remainder 2, div_by_zero 0; done exactly in cycle 19; busy high in cycles 1..18.
- -100 / 7 -> quotient -14 (0xFFFFFFF2), remainder -2 (0xFFFFFFFE); 100 / -7 -> -14, 2.
- 7 / 0 -> quotient 0xFFFFFFFF, remainder 7, div_by_zero 1; done in cycle 2.
- 0x80000000 / 0xFFFFFFFF -> quotient 0x80000000, remainder 0. Also 0xFFFFFFFF / 0x80000000 -> 0, 0xFFFFFFFF.
- Start held high in the done cycle with 50/5 after 100/7 -> second done 19 cycles later, quotient 10, remainder 0. Start pulses during busy are ignored.
- rst asserted in cycle 10 of an operation -> next cycle: IDLE, all outputs 0, no done. A new 9/2 then gives quotient 4, remainder 1.

Source files
------------

// File: rtl/seq_radix4_divider_pkg.sv
// Shared definitions for the sequential radix-4 signed divider.
//   - state_t      : controller states
//   - DIV_WIDTH    : default operand width
//   - DBZ_QUOTIENT : quotient reported when the divisor is zero (all ones)
package div_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    PREP = 3'd1,
    ITER = 3'd2,
    FIX  = 3'd3,
    DONE = 3'd4
  } state_t;

  localparam int DIV_WIDTH = 32;

  localparam logic [DIV_WIDTH-1:0] DBZ_QUOTIENT = {DIV_WIDTH{1'b1}};

endpackage

// File: rtl/seq_radix4_divider_digit_select.sv
// Radix-4 restoring digit selection (purely combinational).
// Ports:
//   r_shift : shifted partial remainder R' = {R, next two dividend bits}
//   d1/d2/d3: 1x, 2x, 3x divisor magnitude (WIDTH+2 bits)
//   digit   : largest q in {3,2,1,0} with q*D <= R'
//   r_next  : R' - q*D. It is always below |D| <= 2^(WIDTH-1),
//             so WIDTH bits hold it without loss.
module radix4_digit_select #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH+1:0] r_shift,
  input  logic [WIDTH+1:0] d1,
  input  logic [WIDTH+1:0] d2,
  input  logic [WIDTH+1:0] d3,
  output logic [1:0]       digit,
  output logic [WIDTH-1:0] r_next
);
  import div_pkg::*;

  // Choose the largest divisor multiple that fits and subtract it.
  always_comb begin
    digit  = 2'd0;
    r_next = r_shift[WIDTH-1:0];
    if (r_shift >= d3) begin
      digit  = 2'd3;
      r_next = WIDTH'(r_shift - d3);
    end else if (r_shift >= d2) begin
      digit  = 2'd2;
      r_next = WIDTH'(r_shift - d2);
    end else if (r_shift >= d1) begin
      digit  = 2'd1;
      r_next = WIDTH'(r_shift - d1);
    end else begin
      digit  = 2'd0;
      r_next = r_shift[WIDTH-1:0];
    end
  end

endmodule

// File: rtl/seq_radix4_divider.sv
// Sequential signed radix-4 restoring divider, two quotient bits per clock.
// Works on operand magnitudes and fixes the signs in a final step.
// Ports:
//   clk, rst          : clock, synchronous active-high reset
//   start             : request, taken only in IDLE or DONE
//   dividend, divisor : signed operands, captured with start
//   busy              : high from the cycle after acceptance until before done
//   done              : one-cycle pulse, results valid from this cycle
//   quotient          : signed quotient, truncated toward zero
//   remainder         : signed remainder with the dividend's sign
//   div_by_zero       : divisor was zero (quotient all ones, remainder = dividend)
module seq_radix4_divider #(
  parameter int WIDTH = div_pkg::DIV_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);
  import div_pkg::*;

  localparam int              CNT_W    = (WIDTH / 2 > 1) ? $clog2(WIDTH / 2) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH / 2 - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [WIDTH-1:0] ZERO_W   = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] DBZ_Q    = {WIDTH{DBZ_QUOTIENT[0]}};

  // Two's-complement negation, wrapping (so -(-2^(W-1)) stays 2^(W-1) unsigned).
  function automatic logic [WIDTH-1:0] negate(input logic [WIDTH-1:0] x);
    return ~x + {{(WIDTH-1){1'b0}}, 1'b1};
  endfunction

  // Unsigned magnitude of a signed operand; -2^(W-1) maps to 2^(W-1).
  function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] x);
    return x[WIDTH-1] ? negate(x) : x;
  endfunction

  state_t             state_r, state_next_s;
  logic [CNT_W-1:0]   cnt_r;
  logic [WIDTH-1:0]   dividend_r, divisor_r;
  logic               sign_n_r, sign_d_r;
  logic [WIDTH-1:0]   n_r;        // dividend magnitude, consumed MSB-first
  logic [WIDTH-1:0]   rem_r;      // partial remainder, always < |D|
  logic [WIDTH-1:0]   q_r;        // quotient magnitude being assembled
  logic [WIDTH+1:0]   d1_r, d2_r, d3_r;
  logic [WIDTH-1:0]   d_mag_s;
  logic [WIDTH+1:0]   r_shift_s;
  logic [1:0]         digit_s;
  logic [WIDTH-1:0]   r_next_s;
  logic               busy_s, done_s;

  assign d_mag_s   = magnitude(divisor_r);
  assign r_shift_s = {rem_r, n_r[WIDTH-1:WIDTH-2]};

  radix4_digit_select #(.WIDTH(WIDTH)) u_digit_select (
    .r_shift (r_shift_s),
    .d1      (d1_r),
    .d2      (d2_r),
    .d3      (d3_r),
    .digit   (digit_s),
    .r_next  (r_next_s)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state logic.
  always_comb begin
    state_next_s = IDLE;
    case (state_r)
      IDLE:    state_next_s = start ? PREP : IDLE;
      PREP:    state_next_s = (divisor_r == ZERO_W) ? DONE : ITER;
      ITER:    state_next_s = (cnt_r == {CNT_W{1'b0}}) ? FIX : ITER;
      FIX:     state_next_s = DONE;
      DONE:    state_next_s = start ? PREP : IDLE;
      default: state_next_s = IDLE;
    endcase
  end

  // Status decode from the upcoming state, so busy/done come out of flops.
  always_comb begin
    busy_s = 1'b0;
    done_s = 1'b0;
    case (state_next_s)
      PREP, ITER, FIX: busy_s = 1'b1;
      DONE:            done_s = 1'b1;
      default: begin
        busy_s = 1'b0;
        done_s = 1'b0;
      end
    endcase
  end

  // Registered status outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      busy <= busy_s;
      done <= done_s;
    end
  end

  // Operand capture, magnitude preparation and the radix-4 iteration.
  always_ff @(posedge clk) begin
    if (rst) begin
      dividend_r <= ZERO_W;
      divisor_r  <= ZERO_W;
      sign_n_r   <= 1'b0;
      sign_d_r   <= 1'b0;
      n_r        <= ZERO_W;
      rem_r      <= ZERO_W;
      q_r        <= ZERO_W;
      d1_r       <= {(WIDTH+2){1'b0}};
      d2_r       <= {(WIDTH+2){1'b0}};
      d3_r       <= {(WIDTH+2){1'b0}};
      cnt_r      <= {CNT_W{1'b0}};
    end else begin
      case (state_r)
        IDLE, DONE: begin
          if (start) begin
            dividend_r <= dividend;
            divisor_r  <= divisor;
            sign_n_r   <= dividend[WIDTH-1];
            sign_d_r   <= divisor[WIDTH-1];
          end else begin
            dividend_r <= dividend_r;
          end
        end
        PREP: begin
          n_r   <= magnitude(dividend_r);
          d1_r  <= {2'b00, d_mag_s};
          d2_r  <= {1'b0, d_mag_s, 1'b0};
          d3_r  <= {2'b00, d_mag_s} + {1'b0, d_mag_s, 1'b0};
          rem_r <= ZERO_W;
          q_r   <= ZERO_W;
          cnt_r <= CNT_LAST;
        end
        ITER: begin
          n_r   <= {n_r[WIDTH-3:0], 2'b00};
          rem_r <= r_next_s;
          q_r   <= {q_r[WIDTH-3:0], digit_s};
          if (cnt_r != {CNT_W{1'b0}}) begin
            cnt_r <= cnt_r - CNT_ONE;
          end else begin
            cnt_r <= cnt_r;
          end
        end
        default: begin
          n_r <= n_r;
        end
      endcase
    end
  end

  // Result registers; they only change when a new result is produced.
  always_ff @(posedge clk) begin
    if (rst) begin
      quotient    <= ZERO_W;
      remainder   <= ZERO_W;
      div_by_zero <= 1'b0;
    end else if ((state_r == PREP) && (divisor_r == ZERO_W)) begin
      quotient    <= DBZ_Q;
      remainder   <= dividend_r;
      div_by_zero <= 1'b1;
    end else if (state_r == FIX) begin
      quotient    <= (sign_n_r ^ sign_d_r) ? negate(q_r) : q_r;
      remainder   <= sign_n_r ? negate(rem_r) : rem_r;
      div_by_zero <= 1'b0;
    end else begin
      quotient    <= quotient;
      remainder   <= remainder;
      div_by_zero <= div_by_zero;
    end
  end

endmodule

// File: tb/tb_seq_radix4_divider.sv
// Self-checking bench for seq_radix4_divider (WIDTH=32): directed table,
// back-to-back / busy-start / mid-operation reset sequences, and random
// operands checked against a plain integer-division reference.
module tb_seq_radix4_divider;

  logic        clk = 1'b0;
  logic        rst, start;
  logic [31:0] dividend, divisor;
  logic        busy, done, div_by_zero;
  logic [31:0] quotient, remainder;

  int total, bad;

  seq_radix4_divider #(.WIDTH(32)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] q;
    logic [31:0] r;
    logic        z;
    int          lat;
  } vec_t;

  vec_t vecs[11];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Reference: signed integer division on 64-bit values, truncated to 32 bits.
  function automatic void ref_div(input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] q, output logic [31:0] r,
                                  output logic z);
    longint la, lb, lq, lr;
    la = longint'($signed(a));
    lb = longint'($signed(b));
    if (lb == 0) begin
      q = 32'hFFFF_FFFF;
      r = a;
      z = 1'b1;
    end else begin
      lq = la / lb;
      lr = la % lb;
      q  = lq[31:0];
      r  = lr[31:0];
      z  = 1'b0;
    end
  endfunction

  // Drive a start request during cycle 0.
  task automatic issue(input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    start    = 1'b1;
    dividend = a;
    divisor  = b;
  endtask

  // Count cycles after acceptance until done; optionally pulse start at
  // cycle glitch_k with unrelated operands (must be ignored while busy).
  task automatic wait_done(input int glitch_k, output logic [31:0] q, output logic [31:0] r,
                           output logic z, output int lat, output int busy_err);
    lat = -1; busy_err = 0; q = 32'd0; r = 32'd0; z = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (k == glitch_k) begin
        start = 1'b1; dividend = 32'd999; divisor = 32'd3;
      end else begin
        start = 1'b0;
      end
      if (done) begin
        lat = k; q = quotient; r = remainder; z = div_by_zero;
        break;
      end
      if (!busy) busy_err++;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] q, r, eq, er;
    logic        z, ez;
    int          lat, berr, n_done;

    total = 0; bad = 0;
    rst = 1'b1; start = 1'b0; dividend = 32'd0; divisor = 32'd0;
    repeat (3) @(negedge clk);
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_done", {31'd0, done}, 32'd0);
    check("reset_quot", quotient, 32'd0);
    check("reset_rem", remainder, 32'd0);
    check("reset_dbz", {31'd0, div_by_zero}, 32'd0);
    rst = 1'b0;

    vecs[0]  = '{32'd100,       32'd7,         32'd14,        32'd2,         1'b0, 19};
    vecs[1]  = '{32'hFFFF_FF9C, 32'd7,         32'hFFFF_FFF2, 32'hFFFF_FFFE, 1'b0, 19};
    vecs[2]  = '{32'd100,       32'hFFFF_FFF9, 32'hFFFF_FFF2, 32'd2,         1'b0, 19};
    vecs[3]  = '{32'd7,         32'd0,         32'hFFFF_FFFF, 32'd7,         1'b1, 2};
    vecs[4]  = '{32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0,         1'b0, 19};
    vecs[5]  = '{32'hFFFF_FFFF, 32'h8000_0000, 32'd0,         32'hFFFF_FFFF, 1'b0, 19};
    vecs[6]  = '{32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFFF, 32'hFFFF_FFF9, 1'b1, 2};
    vecs[7]  = '{32'd0,         32'd5,         32'd0,         32'd0,         1'b0, 19};
    vecs[8]  = '{32'h7FFF_FFFF, 32'd1,         32'h7FFF_FFFF, 32'd0,         1'b0, 19};
    vecs[9]  = '{32'h8000_0000, 32'h8000_0000, 32'd1,         32'd0,         1'b0, 19};
    vecs[10] = '{32'h8000_0000, 32'd7,         32'hEDB6_DB6E, 32'hFFFF_FFFE, 1'b0, 19};

    foreach (vecs[i]) begin
      issue(vecs[i].a, vecs[i].b);
      wait_done(0, q, r, z, lat, berr);
      check($sformatf("vec%0d_quot", i), q, vecs[i].q);
      check($sformatf("vec%0d_rem", i), r, vecs[i].r);
      check($sformatf("vec%0d_dbz", i), {31'd0, z}, {31'd0, vecs[i].z});
      check($sformatf("vec%0d_lat", i), 32'(lat), 32'(vecs[i].lat));
      check($sformatf("vec%0d_busy", i), 32'(berr), 32'd0);
      @(negedge clk);
      check($sformatf("vec%0d_done_pulse", i), {31'd0, done}, 32'd0);
      check($sformatf("vec%0d_hold", i), quotient, vecs[i].q);
    end

    // Back-to-back: 100/7 with a start pulse during busy, then 50/5 started in the done cycle.
    issue(32'd100, 32'd7);
    wait_done(5, q, r, z, lat, berr);
    check("b2b_first_quot", q, 32'd14);
    check("b2b_first_rem", r, 32'd2);
    check("b2b_first_lat", 32'(lat), 32'd19);
    start = 1'b1; dividend = 32'd50; divisor = 32'd5;
    wait_done(0, q, r, z, lat, berr);
    check("b2b_second_quot", q, 32'd10);
    check("b2b_second_rem", r, 32'd0);
    check("b2b_second_lat", 32'(lat), 32'd19);
    check("b2b_second_busy", 32'(berr), 32'd0);
    @(negedge clk);
    check("b2b_no_queue_busy", {31'd0, busy}, 32'd0);

    // Reset asserted during cycle 10 of an operation.
    issue(32'd100, 32'd7);
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_busy", {31'd0, busy}, 32'd0);
    check("midrst_done", {31'd0, done}, 32'd0);
    check("midrst_quot", quotient, 32'd0);
    check("midrst_rem", remainder, 32'd0);
    check("midrst_dbz", {31'd0, div_by_zero}, 32'd0);
    rst = 1'b0;
    n_done = 0;
    repeat (25) begin
      @(negedge clk);
      if (done) n_done++;
    end
    check("midrst_no_done", 32'(n_done), 32'd0);
    issue(32'd9, 32'd2);
    wait_done(0, q, r, z, lat, berr);
    check("after_rst_quot", q, 32'd4);
    check("after_rst_rem", r, 32'd1);
    check("after_rst_lat", 32'(lat), 32'd19);

    // Random operands against the reference.
    for (int i = 0; i < 60; i++) begin
      int          sel;
      logic [31:0] a, b;
      sel = $urandom_range(0, 7);
      a   = $urandom;
      if (sel == 0) begin
        b = 32'd0;
      end else if (sel < 4) begin
        b = 32'($urandom_range(1, 9));
        if ($urandom_range(0, 1) == 1) b = -b;
      end else begin
        b = $urandom;
      end
      if (sel == 7) a = 32'h8000_0000;
      ref_div(a, b, eq, er, ez);
      issue(a, b);
      wait_done(0, q, r, z, lat, berr);
      check($sformatf("rnd%0d_quot", i), q, eq);
      check($sformatf("rnd%0d_rem", i), r, er);
      check($sformatf("rnd%0d_dbz", i), {31'd0, z}, {31'd0, ez});
      check($sformatf("rnd%0d_lat", i), 32'(lat), (b == 32'd0) ? 32'd2 : 32'd19);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
